// File: rtl/pwm_ramp_scheduler.sv
// pwm_ramp_scheduler: per-channel duty slew scheduler for the 3-channel PWM core.
// Targets and steps are written through a valid/ready port while idle. Each
// accepted period boundary runs a three-state update pass that moves every
// channel's applied duty toward its target by at most its step.
module pwm_ramp_scheduler #(
  parameter int DUTY_W = 7,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [1:0]        wr_ch,
  input  logic [DUTY_W-1:0] wr_target,
  input  logic [STEP_W-1:0] wr_step,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty0,
  output logic [DUTY_W-1:0] duty1,
  output logic [DUTY_W-1:0] duty2,
  output logic [2:0]        ramp_active,
  output logic [2:0]        reached,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UPD0 = 2'd1,
    UPD1 = 2'd2,
    UPD2 = 2'd3
  } state_t;

  state_t            state_q;
  logic [DUTY_W-1:0] duty_q   [3];
  logic [DUTY_W-1:0] target_q [3];
  logic [STEP_W-1:0] step_q   [3];
  logic [2:0]        reached_q;
  logic              err_q;

  logic              wr_fire;
  logic              upd_en;
  logic [1:0]        upd_ch;
  logic [DUTY_W-1:0] cur_duty;
  logic [DUTY_W-1:0] cur_target;
  logic [STEP_W-1:0] cur_step;
  logic [DUTY_W-1:0] duty_d;
  logic              reach_d;

  // Write handshake; reset gates ready so nothing is accepted while held in reset.
  always_comb begin
    wr_ready = ena & rst_n & (state_q == IDLE);
    wr_fire  = wr_valid & wr_ready;
  end

  // Select the channel owned by the current update state.
  always_comb begin
    upd_en     = ena & (state_q != IDLE);
    upd_ch     = 2'd0;
    cur_duty   = duty_q[0];
    cur_target = target_q[0];
    cur_step   = step_q[0];
    case (state_q)
      UPD1: begin
        upd_ch     = 2'd1;
        cur_duty   = duty_q[1];
        cur_target = target_q[1];
        cur_step   = step_q[1];
      end
      UPD2: begin
        upd_ch     = 2'd2;
        cur_duty   = duty_q[2];
        cur_target = target_q[2];
        cur_step   = step_q[2];
      end
      default: ;
    endcase
  end

  // Slew arithmetic one bit wider than the duty so up-steps cannot wrap;
  // a down-step only subtracts when the gap exceeds the step, so it cannot underflow.
  always_comb begin
    logic [DUTY_W:0] w_duty;
    logic [DUTY_W:0] w_tgt;
    logic [DUTY_W:0] w_step;
    logic [DUTY_W:0] up_sum;
    logic [DUTY_W:0] dn_gap;
    logic [DUTY_W:0] dn_val;
    w_duty = {1'b0, cur_duty};
    w_tgt  = {1'b0, cur_target};
    w_step = (DUTY_W+1)'(cur_step);
    up_sum = w_duty + w_step;
    dn_gap = w_duty - w_tgt;
    dn_val = w_duty - w_step;
    duty_d = cur_duty;
    if (cur_step == '0) begin
      duty_d = cur_target;
    end else if (w_duty < w_tgt) begin
      duty_d = (up_sum >= w_tgt) ? cur_target : up_sum[DUTY_W-1:0];
    end else if (w_duty > w_tgt) begin
      duty_d = (dn_gap <= w_step) ? cur_target : dn_val[DUTY_W-1:0];
    end
    reach_d = (cur_duty != cur_target) && (duty_d == cur_target);
  end

  // Update-sequence FSM with config capture and registered duty/reached/err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      reached_q <= '0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        duty_q[i]   <= '0;
        target_q[i] <= '0;
        step_q[i]   <= '0;
      end
    end else begin
      reached_q <= '0;

      if (wr_fire) begin
        if (wr_ch == 2'd3) begin
          err_q <= 1'b1;
        end else begin
          for (int unsigned i = 0; i < 3; i++) begin
            if (wr_ch == 2'(i)) begin
              target_q[i] <= wr_target;
              step_q[i]   <= wr_step;
            end
          end
        end
      end

      if (!ena) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE:    state_q <= period_end ? UPD0 : IDLE;
          UPD0:    state_q <= UPD1;
          UPD1:    state_q <= UPD2;
          default: state_q <= IDLE;
        endcase
      end

      if (upd_en) begin
        for (int unsigned i = 0; i < 3; i++) begin
          if (upd_ch == 2'(i)) begin
            duty_q[i]    <= duty_d;
            reached_q[i] <= reach_d;
          end
        end
      end
    end
  end

  // Ramp status follows the registered duty/target pairs directly.
  always_comb begin
    ramp_active = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      ramp_active[i] = (duty_q[i] != target_q[i]);
    end
  end

  assign duty0   = duty_q[0];
  assign duty1   = duty_q[1];
  assign duty2   = duty_q[2];
  assign reached = reached_q;
  assign err     = err_q;

endmodule
